// File: rtl/oam_sprite_scanner_pkg.sv
// Shared types for the mode-2 OAM search: per-line sprite list layout,
// scan constants and the scanner state encoding.
package oam_sprite_scanner_pkg;

  localparam int NUM_SPRITES          = 40;
  localparam int OAM_Y_OFFSET         = 16;
  localparam int MAX_SPRITES_PER_LINE = 10;

  typedef struct packed {
    logic [5:0] oam_index;
    logic [7:0] x_position;
    logic [3:0] row;
  } line_sprite_t;

  typedef line_sprite_t [0:MAX_SPRITES_PER_LINE-1] line_sprite_list_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } scan_state_t;

endpackage

// File: rtl/oam_sprite_scanner_y_match.sv
// Decides whether one OAM entry covers the current line and, if so, which
// row of the sprite lands on it.
module oam_y_match
  import oam_sprite_scanner_pkg::*;
(
  input  logic [7:0] ly,
  input  logic [7:0] oam_y,
  input  logic       sprite_size,
  output logic       hit,
  output logic [3:0] row
);

  logic [8:0] line_top;
  logic [8:0] d;
  logic [8:0] h;

  // 9-bit math so ly+16 never wraps; the >= test is the "no borrow" condition.
  always_comb begin
    line_top = {1'b0, ly} + 9'(OAM_Y_OFFSET);
    d        = line_top - {1'b0, oam_y};
    h        = sprite_size ? 9'd16 : 9'd8;
    hit      = (line_top >= {1'b0, oam_y}) && (d < h);
    row      = d[3:0];
  end

endmodule

// File: rtl/oam_sprite_scanner.sv
// Mode-2 OAM search: walks all 40 entries at 2 clocks each and keeps the
// first 10 that cover the latched line, readable by slot index.
module oam_sprite_scanner
  import oam_sprite_scanner_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  ly,
  input  logic        sprite_size,
  output logic [5:0]  oam_addr,
  input  logic [7:0]  oam_y,
  input  logic [7:0]  oam_x,
  output logic        busy,
  output logic        done,
  output logic [3:0]  sprite_count,
  input  logic [3:0]  rd_idx,
  output logic [5:0]  rd_oam_index,
  output logic [7:0]  rd_x,
  output logic [3:0]  rd_row,
  output scan_state_t state_dbg
);

  scan_state_t       state;
  logic [7:0]        ly_q;
  logic              size_q;
  logic [5:0]        n;
  line_sprite_list_t list;
  logic              hit;
  logic [3:0]        row;
  line_sprite_t      rd_ent;

  oam_y_match u_y_match (
    .ly          (ly_q),
    .oam_y       (oam_y),
    .sprite_size (size_q),
    .hit         (hit),
    .row         (row)
  );

  // oam_addr is loaded on entry to READ so the RAM output is valid in EVAL.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      oam_addr     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sprite_count <= '0;
      list         <= '0;
      n            <= '0;
      ly_q         <= '0;
      size_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            ly_q         <= ly;
            size_q       <= sprite_size;
            sprite_count <= '0;
            list         <= '0;
            n            <= '0;
            oam_addr     <= '0;
            busy         <= 1'b1;
            state        <= ST_READ;
          end
        end
        ST_READ: state <= ST_EVAL;
        ST_EVAL: begin
          if (hit && (sprite_count < 4'(MAX_SPRITES_PER_LINE))) begin
            list[sprite_count] <= '{oam_index: n, x_position: oam_x, row: row};
            sprite_count       <= sprite_count + 4'd1;
          end
          if (n == 6'(NUM_SPRITES - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            n        <= n + 6'd1;
            oam_addr <= n + 6'd1;
            state    <= ST_READ;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_ent = '0;
    if ((rd_idx < sprite_count) && (rd_idx < 4'(MAX_SPRITES_PER_LINE)))
      rd_ent = list[rd_idx];
  end

  assign rd_oam_index = rd_ent.oam_index;
  assign rd_x         = rd_ent.x_position;
  assign rd_row       = rd_ent.row;
  assign state_dbg    = state;

endmodule

// File: tb/tb_oam_sprite_scanner.sv
// Bench for oam_sprite_scanner: directed line scenarios plus random OAM
// contents, checked against a list-building reference model.
module tb_oam_sprite_scanner;
  import oam_sprite_scanner_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  ly;
  logic        sprite_size;
  logic [5:0]  oam_addr;
  logic [7:0]  oam_y;
  logic [7:0]  oam_x;
  logic        busy;
  logic        done;
  logic [3:0]  sprite_count;
  logic [3:0]  rd_idx;
  logic [5:0]  rd_oam_index;
  logic [7:0]  rd_x;
  logic [3:0]  rd_row;
  scan_state_t state_dbg;

  logic [7:0]  mem_y [0:39];
  logic [7:0]  mem_x [0:39];
  logic [17:0] exp_q [$];

  int total = 0;
  int bad   = 0;

  oam_sprite_scanner dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .ly           (ly),
    .sprite_size  (sprite_size),
    .oam_addr     (oam_addr),
    .oam_y        (oam_y),
    .oam_x        (oam_x),
    .busy         (busy),
    .done         (done),
    .sprite_count (sprite_count),
    .rd_idx       (rd_idx),
    .rd_oam_index (rd_oam_index),
    .rd_x         (rd_x),
    .rd_row       (rd_row),
    .state_dbg    (state_dbg)
  );

  // clock / OAM RAM with one-cycle read latency
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    oam_y <= (oam_addr < 6'd40) ? mem_y[oam_addr] : 8'd0;
    oam_x <= (oam_addr < 6'd40) ? mem_x[oam_addr] : 8'd0;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // reference: the first 10 entries in OAM order whose sprite covers the line
  task automatic build_model(input int l, input int sz);
    int h;
    int top;
    exp_q.delete();
    h = sz ? 16 : 8;
    top = l + 16;
    for (int i = 0; i < 40; i++) begin
      if (top >= int'(mem_y[i]) && (top - int'(mem_y[i])) < h && exp_q.size() < 10)
        exp_q.push_back({6'(i), mem_x[i], 4'(top - int'(mem_y[i]))});
    end
  endtask

  task automatic check_list(input string tag);
    logic [17:0] e;
    check_val({tag, ".count"}, 32'(sprite_count), 32'(exp_q.size()));
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      @(negedge clk);
      e = (i < exp_q.size()) ? exp_q[i] : 18'd0;
      check_val($sformatf("%s.slot%0d", tag, i), 32'({rd_oam_index, rd_x, rd_row}), 32'(e));
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 40; i++) begin
      mem_y[i] = 8'd0;
      mem_x[i] = 8'($urandom_range(0, 255));
    end
  endtask

  // one scan; optional stray start at cycle extra; ly/size scrambled mid-scan
  task automatic run_scan(input string tag, input logic [7:0] l, input logic sz, input int extra);
    int busy_cnt;
    int done_cnt;
    int done_at;
    build_model(int'(l), int'(sz));
    ly = l;
    sprite_size = sz;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0;
    done_at = -1;
    for (int k = 1; k <= 84; k++) begin
      start = (k == extra) ? 1'b1 : 1'b0;
      ly = 8'($urandom_range(0, 255));
      sprite_size = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
    start = 1'b0;
    check_val({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd80);
    check_val({tag, ".done_at"}, 32'(done_at), 32'd80);
    check_val({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
    check_list(tag);
  endtask

  task automatic run_reset_abort();
    int done_cnt;
    ly = 8'd0;
    sprite_size = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k < 40; k++) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_val("abort.busy", 32'(busy), 32'd0);
    check_val("abort.count", 32'(sprite_count), 32'd0);
    rd_idx = 4'd0;
    #1;
    check_val("abort.slot0", 32'({rd_oam_index, rd_x, rd_row}), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check_val("abort.no_done", 32'(done_cnt), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    ly = 8'd0;
    sprite_size = 1'b0;
    rd_idx = 4'd0;
    for (int i = 0; i < 40; i++) begin
      mem_y[i] = 8'd0;
      mem_x[i] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.busy", 32'(busy), 32'd0);
    check_val("rst.done", 32'(done), 32'd0);
    check_val("rst.count", 32'(sprite_count), 32'd0);
    check_val("rst.oam_addr", 32'(oam_addr), 32'd0);
    check_val("rst.slot0", 32'({rd_oam_index, rd_x, rd_row}), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // single sprite at top of screen
    clear_mem();
    mem_y[5] = 8'd16;
    mem_x[5] = 8'd8;
    run_scan("single", 8'd0, 1'b0, -1);
    rd_idx = 4'd0;
    #1;
    check_val("single.const", 32'({rd_oam_index, rd_x, rd_row}), 32'({6'd5, 8'd8, 4'd0}));

    // 8x8 row edges
    clear_mem();
    mem_y[0] = 8'd29;
    mem_y[1] = 8'd28;
    mem_y[2] = 8'd36;
    mem_y[3] = 8'd37;
    run_scan("edge8", 8'd20, 1'b0, -1);

    // tall sprites: rows 14/15 in 8x16, misses in 8x8
    clear_mem();
    mem_y[0] = 8'd12;
    mem_y[1] = 8'd11;
    run_scan("tall16", 8'd10, 1'b1, -1);
    run_scan("tall8", 8'd10, 1'b0, -1);

    // overflow past 10, with a stray start at cycle 30
    for (int i = 0; i < 40; i++) begin
      mem_y[i] = 8'd16;
      mem_x[i] = 8'($urandom_range(0, 255));
    end
    run_scan("full", 8'd0, 1'b0, 30);
    rd_idx = 4'd12;
    #1;
    check_val("full.rd12", 32'({rd_oam_index, rd_x, rd_row}), 32'd0);

    run_reset_abort();

    // X not filtered
    clear_mem();
    mem_y[3] = 8'd16;
    mem_x[3] = 8'd0;
    mem_y[7] = 8'd16;
    mem_x[7] = 8'd200;
    run_scan("xfilt", 8'd0, 1'b0, -1);
    rd_idx = 4'd1;
    #1;
    check_val("xfilt.x200", 32'(rd_x), 32'd200);

    // random OAM clustered around the line
    for (int t = 0; t < 20; t++) begin
      logic [7:0] l;
      logic sz;
      l = 8'($urandom_range(0, 255));
      sz = 1'($urandom_range(0, 1));
      for (int i = 0; i < 40; i++) begin
        mem_x[i] = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) mem_y[i] = 8'($urandom_range(0, 255));
        else mem_y[i] = 8'(int'(l) + 16 - int'($urandom_range(0, 18)));
      end
      run_scan($sformatf("rand%0d", t), l, sz, $urandom_range(0, 1) ? int'($urandom_range(1, 79)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
